// File: rtl/controle_tentativas_pkg.sv
// Shared constants for the attempt-control lock: state encoding and attempt-counter width.
package controle_tentativas_pkg;

    localparam int TENT_W = 3;

    localparam logic [2:0] ESPERA    = 3'd0;
    localparam logic [2:0] ERRO      = 3'd1;
    localparam logic [2:0] ABERTO    = 3'd2;
    localparam logic [2:0] BLOQUEADO = 3'd3;

endpackage

// File: rtl/controle_tentativas_timer.sv
// contador_timer: up-counter with synchronous clear, enable and terminal-count flag.
module contador_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] contagem;

    always_ff @(posedge clock) begin
        if (clear)
            contagem <= '0;
        else if (en)
            contagem <= contagem + 1'b1;
    end

    assign fim = (contagem == limite);

endmodule

// File: rtl/controle_tentativas.sv
// Code-entry attempt controller with timed unlock and lockout after repeated failures.
// Optional hint outputs enabled by defining CONTROLE_TENTATIVAS_DICA_EN.
module controle_tentativas
    import controle_tentativas_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TEMPO_ABERTO   = 50_000_000,
    parameter int TEMPO_BLOQUEIO = 500_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              verificar,
    input  logic              AEB,
    input  logic              ALB,
    input  logic              AGB,
    output logic              pronto,
    output logic              liberado,
    output logic              erro,
    output logic              bloqueado,
    output logic [TENT_W-1:0] tentativas,
    output logic              dica_maior,
    output logic              dica_menor,
    output logic [2:0]        estado
);

    localparam int TMAX = (TEMPO_ABERTO > TEMPO_BLOQUEIO) ? TEMPO_ABERTO : TEMPO_BLOQUEIO;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]     LIM_ABERTO    = TW'(TEMPO_ABERTO - 1);
    localparam logic [TW-1:0]     LIM_BLOQUEIO  = TW'(TEMPO_BLOQUEIO - 1);
    localparam logic [TENT_W-1:0] MAX_T         = TENT_W'(MAX_TENTATIVAS);

    logic [2:0]        estado_d;
    logic [TENT_W-1:0] tent_d;
    logic [TENT_W-1:0] tent_inc;
    logic              valido;
    logic              acerto;
    logic              fim;
    logic              timer_clear;
    logic              timer_en;
    logic [TW-1:0]     timer_limite;

    assign valido   = (AEB & ~ALB & ~AGB) | (~AEB & ALB & ~AGB) | (~AEB & ~ALB & AGB);
    assign acerto   = valido & AEB;
    assign tent_inc = (tentativas < MAX_T) ? tentativas + 1'b1 : tentativas;

    always_comb begin
        estado_d = estado;
        tent_d   = tentativas;
        case (estado)
            ESPERA: begin
                if (verificar) begin
                    if (acerto) begin
                        estado_d = ABERTO;
                        tent_d   = '0;
                    end else begin
                        tent_d   = tent_inc;
                        estado_d = (tent_inc == MAX_T) ? BLOQUEADO : ERRO;
                    end
                end
            end
            ERRO:      estado_d = ESPERA;
            ABERTO:    if (fim) estado_d = ESPERA;
            BLOQUEADO: begin
                if (fim) begin
                    estado_d = ESPERA;
                    tent_d   = '0;
                end
            end
            default:   estado_d = ESPERA;
        endcase
    end

    // Any state change restarts the dwell count, so the timer reads 0 on the first cycle of each state.
    assign timer_clear  = reset | (estado_d != estado);
    assign timer_en     = (estado == ABERTO) | (estado == BLOQUEADO);
    assign timer_limite = (estado == ABERTO) ? LIM_ABERTO : LIM_BLOQUEIO;

    contador_timer #(.W(TW)) u_timer (
        .clock  (clock),
        .clear  (timer_clear),
        .en     (timer_en),
        .limite (timer_limite),
        .fim    (fim)
    );

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= ESPERA;
            tentativas <= '0;
            pronto     <= 1'b1;
            liberado   <= 1'b0;
            erro       <= 1'b0;
            bloqueado  <= 1'b0;
        end else begin
            estado     <= estado_d;
            tentativas <= tent_d;
            pronto     <= (estado_d == ESPERA);
            liberado   <= (estado_d == ABERTO);
            erro       <= (estado_d == ERRO);
            bloqueado  <= (estado_d == BLOQUEADO);
        end
    end

`ifdef CONTROLE_TENTATIVAS_DICA_EN
    // Hints update on every accepted attempt; a correct code clears both since AGB/ALB are low.
    always_ff @(posedge clock) begin
        if (reset) begin
            dica_maior <= 1'b0;
            dica_menor <= 1'b0;
        end else if ((estado == ESPERA) && verificar) begin
            dica_maior <= valido & AGB;
            dica_menor <= valido & ALB;
        end
    end
`else
    assign dica_maior = 1'b0;
    assign dica_menor = 1'b0;
`endif

endmodule

// File: tb/tb_controle_tentativas.sv
// Self-checking bench for controle_tentativas: directed scenarios plus random traffic vs. a dwell-counter model.
module tb_controle_tentativas;

    localparam int MAXT = 3;
    localparam int TA   = 4;
    localparam int TB   = 8;

    logic       clock = 1'b0;
    logic       reset, verificar, AEB, ALB, AGB;
    logic       pronto, liberado, erro, bloqueado, dica_maior, dica_menor;
    logic [2:0] tentativas, estado;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: remaining dwell cycles rather than a state register
    int open_left, lock_left, m_fails;
    bit erro_pend, m_dmaior, m_dmenor;

    always #5 clock = ~clock;

    controle_tentativas #(
        .MAX_TENTATIVAS (MAXT),
        .TEMPO_ABERTO   (TA),
        .TEMPO_BLOQUEIO (TB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .verificar  (verificar),
        .AEB        (AEB),
        .ALB        (ALB),
        .AGB        (AGB),
        .pronto     (pronto),
        .liberado   (liberado),
        .erro       (erro),
        .bloqueado  (bloqueado),
        .tentativas (tentativas),
        .dica_maior (dica_maior),
        .dica_menor (dica_menor),
        .estado     (estado)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit e, input bit l, input bit g);
        bit one_hot;
        one_hot = (int'(e) + int'(l) + int'(g)) == 1;
        if (r) begin
            open_left = 0; lock_left = 0; m_fails = 0; erro_pend = 0;
            m_dmaior = 0; m_dmenor = 0;
        end else if (open_left > 0) begin
            open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) m_fails = 0;
        end else if (erro_pend) begin
            erro_pend = 0;
        end else if (v) begin
            if (one_hot && e) begin
                m_fails = 0;
                open_left = TA;
                m_dmaior = 0; m_dmenor = 0;
            end else begin
                if (m_fails < MAXT) m_fails++;
                if (m_fails == MAXT) lock_left = TB;
                else erro_pend = 1;
                m_dmaior = one_hot && g;
                m_dmenor = one_hot && l;
            end
        end
    endtask

    task automatic check_all();
        bit idle;
        int exp_state;
        idle = (open_left == 0) && (lock_left == 0) && !erro_pend;
        exp_state = (open_left > 0) ? 2 : (lock_left > 0) ? 3 : erro_pend ? 1 : 0;
        check("pronto", 32'(pronto), 32'(idle));
        check("liberado", 32'(liberado), 32'(open_left > 0));
        check("bloqueado", 32'(bloqueado), 32'(lock_left > 0));
        check("erro", 32'(erro), 32'(erro_pend));
        check("tentativas", 32'(tentativas), 32'(m_fails));
        check("estado", 32'(estado), 32'(exp_state));
`ifdef CONTROLE_TENTATIVAS_DICA_EN
        check("dica_maior", 32'(dica_maior), 32'(m_dmaior));
        check("dica_menor", 32'(dica_menor), 32'(m_dmenor));
`else
        check("dica_maior", 32'(dica_maior), 32'(0));
        check("dica_menor", 32'(dica_menor), 32'(0));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
    task automatic cyc(input bit r, input bit v, input bit e, input bit l, input bit g);
        reset = r; verificar = v; AEB = e; ALB = l; AGB = g;
        @(posedge clock);
        model_step(r, v, e, l, g);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; verificar = 0; AEB = 0; ALB = 0; AGB = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        // Correct code opens for TA cycles
        cyc(0, 1, 1, 0, 0);
        idle(TA + 2);

        // Three low guesses, then lockout; a correct code during lockout is ignored
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 1, 0);
            if (k < 2) cyc(0, 0, 0, 0, 0);
        end
        idle(2);
        cyc(0, 1, 1, 0, 0);
        idle(TB);

        // Two failures, success resets the count, next failure counts from one
        cyc(0, 1, 0, 0, 1); idle(1);
        cyc(0, 1, 0, 1, 0); idle(1);
        cyc(0, 1, 1, 0, 0); idle(TA + 1);
        cyc(0, 1, 0, 0, 1); idle(1);

        // Reset in the middle of an open window
        cyc(0, 1, 1, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        // Non-one-hot comparator inputs count as failures with no hint
        cyc(0, 1, 1, 1, 0); idle(1);
        cyc(0, 1, 0, 0, 0); idle(1);
        cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            logic [2:0] c;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) c = 3'($urandom_range(0, 7));
            else c = 3'(1 << $urandom_range(0, 2));
            cyc(r, v, c[0], c[1], c[2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
